aes_in_packer: RTL
==================

# aes_in_packer

Upstream feeder for `aes_engine`. It accepts 128-bit AES jobs as four 32-bit beats on a narrow valid/ready write port and assembles each job into an `in_packet_t`. Complete jobs are buffered in a small FIFO, and the head job is presented on `data_out`, which connects directly to the engine's `data_in`. An entry is retired when the engine pulses `load_data`.

## Interface
- `DEPTH`, default 4: FIFO entries (complete 128-bit jobs). Must be a power of 2 and at least 2.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `wr_valid  in  1`: a write beat is present.
- `wr_ready  out  1`: the packer accepts the beat at this edge.
- `wr_data  in  32`: beat payload.
- `wr_en_de  in  1`: encrypt/decrypt select. Sampled on beat 3 only.
- `wr_set_key  in  1`: marks the job as a key load. Sampled on beat 3 only.
- `flush  in  1`: synchronous clear of the partial block and the FIFO.
- `data_out  out  in_packet_t`: `{valid, data[127:0], en_de, set_key}` to `aes_engine.data_in`.
- `load_data  in  1`: the engine consumes `data_out` at this edge.
- `count  out  $clog2(DEPTH)+1`: number of complete jobs buffered.

## Operation
- **Beat counter** `beat_cnt` (2 bits, 0→3, wraps to 0).
  - A beat is accepted when `wr_valid && wr_ready`.
  - Beat k is stored to `data[127-32k -: 32]`, so beat 0 is the most-significant word.
- **Push.** Accepting beat 3 pushes the job `{data, wr_en_de, wr_set_key}` into the FIFO at the tail, and `beat_cnt` returns to 0.
- **`wr_ready`.** Equals `(beat_cnt != 3) || (count != DEPTH)`.
  - Beats 0–2 are always accepted, even when the FIFO is full.
  - Only beat 3 stalls, and `wr_ready` does not depend on `load_data`.
- **Head presentation.**
  - `data_out.valid = (count != 0)`.
  - When `valid=1`, the remaining fields come from the head entry.
  - When `count == 0`, all fields are 0.
- **Pop.** Occurs when `data_out.valid && load_data`. The head pointer advances.
  - `load_data` is ignored while the FIFO is empty.
- **Ordering.**
  - Jobs are strictly FIFO, so a `set_key` job is never reordered relative to data jobs.
  - `en_de` and `set_key` pass through unmodified.
- **Simultaneous push and pop.** Both occur and `count` is unchanged.
  - Push alone increments `count`; pop alone decrements it.
- **Full.** A push can never occur while full because beat 3 is stalled. There is no overflow path.
- **Empty.** A pop can never occur while empty. There is no underflow path.
- **Pointers.** `$clog2(DEPTH)` bits each, wrapping naturally modulo DEPTH.
- **`flush`.**
  - Highest priority: sets `count=0`, both pointers to 0, and `beat_cnt=0`.
  - Any beat or pop in the same cycle is discarded.
  - `wr_ready` is 1 in the following cycle.

## Timing
- **Reset (asynchronous).** The reset state is held while `rst_n=0`:
  - `data_out` = all zero, including `valid=0`.
  - `count=0`, `beat_cnt=0`, pointers 0.
  - `wr_ready=1`.
  - FIFO storage need not be cleared.
- **Reset mid-operation.** A partial block and all buffered jobs are lost. The first beat after release is beat 0.
- **Latency.** The job is visible on `data_out`, with `valid=1`, in the cycle after the edge that accepts beat 3.
  - Minimum input-to-output latency is therefore 4 beat edges plus 1 cycle.
- **Throughput.** One job per 4 cycles on input. Output can pop one job per cycle.
- **Hold.** `data_out` is stable while `valid=1` and `load_data=0`.
- **After a pop.**
  - The next entry appears in the cycle following the popping edge.
  - If the FIFO becomes empty, `valid` drops in that cycle.
- **`count`.** Registered; it reflects the push/pop of the previous edge.

## Test plan
- **Reset.** Pulse `rst_n` low asynchronously (between edges) → immediately `data_out=0`, `count=0`, `wr_ready=1`.
- **Single job.**
  - Stimulus: beats `0x00112233`, `0x44556677`, `0x8899AABB`, `0xCCDDEEFF`, with `wr_en_de=1` and `wr_set_key=1` on beat 3.
  - Next cycle: `data_out.valid=1`, `data=0x00112233_44556677_8899AABB_CCDDEEFF`, `en_de=1`, `set_key=1`, `count=1`.
  - Hold `load_data=0` for 5 cycles → `data_out` unchanged.
  - One `load_data` pulse → `valid=0` next cycle.
- **Full and stall (DEPTH=4).**
  - Stimulus: 4 jobs written with `load_data=0`.
  - Result: `count=4`. A 5th job's beats 0–2 are accepted, then `wr_ready=0` at beat 3.
  - One pop → beat 3 is accepted the following cycle and `count` returns to 4.
  - Draining then yields jobs 2–5 in order.
- **Simultaneous push/pop.**
  - Stimulus: `count=2`, with beat 3 accepted and `load_data=1` on the same edge.
  - Result: `count` stays 2 and the output order is preserved. Repeat across pointer wrap (more than 8 jobs total).
- **Flush mid-block.**
  - Stimulus: 1 buffered job plus 2 beats of a new job, then `flush=1` together with `wr_valid=1`.
  - Result: `count=0`, `valid=0`, `beat_cnt=0`.
  - The next 4 beats form a job containing only the new words.
- **Reset mid-operation.**
  - Stimulus: `rst_n` asserted with 3 jobs buffered and `beat_cnt=2`.
  - Result: after release, `valid=0`, and a fresh 4-beat job is emitted intact.

Source files
------------

// File: rtl/aes_in_packer.sv
// Assembles four 32-bit write beats into 128-bit AES jobs, buffers complete jobs
// in a small FIFO and presents the head job to aes_engine.data_in.
package aes_in_packer_pkg;
    typedef struct packed {
        logic         valid;
        logic [127:0] data;
        logic         en_de;
        logic         set_key;
    } in_packet_t;
endpackage

module aes_in_packer
    import aes_in_packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [31:0]            wr_data,
    input  logic                   wr_en_de,
    input  logic                   wr_set_key,
    input  logic                   flush,
    output in_packet_t             data_out,
    input  logic                   load_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [1:0]    beat_cnt_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [95:0]   partial_reg;
    logic [129:0]  mem [DEPTH];

    logic last_beat;
    logic accept;
    logic push;
    logic pop;

    assign last_beat = (beat_cnt_reg == 2'd3);
    // Only the closing beat can stall; earlier beats land in the partial register.
    assign wr_ready  = !last_beat || (count_reg != FULL_COUNT);
    assign accept    = wr_valid && wr_ready && !flush;
    assign push      = accept && last_beat;
    assign pop       = (count_reg != '0) && load_data && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial_reg <= '0;
        end else if (accept) begin
            case (beat_cnt_reg)
                2'd0:    partial_reg[95:64] <= wr_data;
                2'd1:    partial_reg[63:32] <= wr_data;
                2'd2:    partial_reg[31:0]  <= wr_data;
                default: partial_reg        <= partial_reg;
            endcase
        end
    end

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {partial_reg, wr_data, wr_en_de, wr_set_key};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else if (flush) begin
            beat_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (accept) begin
                beat_cnt_reg <= beat_cnt_reg + 2'd1;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        if (count_reg != '0) begin
            data_out.valid   = 1'b1;
            data_out.data    = mem[rd_ptr_reg][129:2];
            data_out.en_de   = mem[rd_ptr_reg][1];
            data_out.set_key = mem[rd_ptr_reg][0];
        end
    end

    assign count = count_reg;

endmodule
